instruction_fetcher: RTL

- Per-core fetch stage directly upstream of the instruction decoder.
- When the core enters FETCH, requests the word at current_pc from the program-memory controller over a valid/ready handshake.
- Holds the returned instruction stable through DECODE, and reports its own state to the core scheduler.
- Adds a single-entry reuse buffer (skips memory when the PC repeats) and a fetch-timeout error flag.

---
 rtl/gpu_pkg.sv | 32 +++
 rtl/instruction_fetcher.sv | 125 ++++++++++++
 2 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings for the GPU core pipeline: scheduler states, fetcher states,
// and the NOP opcode. The decoder and scheduler import this package too.
package gpu_pkg;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'b000,
    CS_FETCH   = 3'b001,
    CS_DECODE  = 3'b010,
    CS_REQUEST = 3'b011,
    CS_WAIT    = 3'b100,
    CS_EXECUTE = 3'b101,
    CS_UPDATE  = 3'b110,
    CS_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'b000,
    FS_FETCHING = 3'b001,
    FS_FETCHED  = 3'b010,
    FS_ERROR    = 3'b011
  } fetch_state_e;

  localparam logic [3:0] NOP_OPCODE = 4'b0000;

  // Width of a counter that must be able to hold the value t (at least 1 bit).
  function automatic int cnt_width(input int t);
    int w;
    w = (t <= 0) ? 1 : $clog2(t + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/instruction_fetcher.sv
// Fetch stage: pulls current_pc from program memory over valid/ready, holds the
// word for the decoder, short-circuits repeated PCs through a one-entry buffer.
module instruction_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int TIMEOUT_CYCLES        = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetch_error
);

  localparam int              CW      = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam logic [CW-1:0]   CNT_TO  = CW'(TIMEOUT_CYCLES);

  fetch_state_e                     r_state, w_state_nxt;
  logic                             r_valid, w_valid_nxt;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr, w_addr_nxt;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr, w_instr_nxt;
  logic                             r_err, w_err_nxt;
  logic [CW-1:0]                    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                             r_buf_valid, w_buf_valid_nxt;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_buf_pc, w_buf_pc_nxt;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_buf_word, w_buf_word_nxt;
  logic                             w_fetch_req, w_hit, w_timeout;

  assign w_fetch_req = (core_state == CS_FETCH);
  // A same-cycle flush forces a miss so a reloaded program is never served stale.
  assign w_hit       = r_buf_valid && (r_buf_pc == current_pc) && !flush;
  assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_TO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FS_IDLE;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_instr     <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_buf_valid <= 1'b0;
      r_buf_pc    <= '0;
      r_buf_word  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_valid     <= w_valid_nxt;
      r_addr      <= w_addr_nxt;
      r_instr     <= w_instr_nxt;
      r_err       <= w_err_nxt;
      r_cnt       <= w_cnt_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
      r_buf_word  <= w_buf_word_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_valid_nxt     = r_valid;
    w_addr_nxt      = r_addr;
    w_instr_nxt     = r_instr;
    w_err_nxt       = r_err;
    w_cnt_nxt       = r_cnt;
    w_buf_valid_nxt = r_buf_valid & ~flush;
    w_buf_pc_nxt    = r_buf_pc;
    w_buf_word_nxt  = r_buf_word;
    case (r_state)
      FS_IDLE: begin
        if (w_fetch_req) begin
          if (w_hit) begin
            w_instr_nxt = r_buf_word;
            w_state_nxt = FS_FETCHED;
          end else begin
            w_valid_nxt = 1'b1;
            w_addr_nxt  = current_pc;
            w_cnt_nxt   = '0;
            w_state_nxt = FS_FETCHING;
          end
        end
      end
      // Request completes regardless of core_state; valid never drops mid-handshake.
      FS_FETCHING: begin
        if (mem_read_ready) begin
          w_instr_nxt     = mem_read_data;
          w_buf_pc_nxt    = r_addr;
          w_buf_word_nxt  = mem_read_data;
          w_buf_valid_nxt = ~flush;
          w_valid_nxt     = 1'b0;
          w_state_nxt     = FS_FETCHED;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_timeout) begin
            w_valid_nxt = 1'b0;
            w_err_nxt   = 1'b1;
            w_instr_nxt = '0;  // all-zero word carries NOP_OPCODE
            w_state_nxt = FS_ERROR;
          end
        end
      end
      FS_FETCHED, FS_ERROR: begin
        if (core_state == CS_DECODE) w_state_nxt = FS_IDLE;
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  assign mem_read_valid   = r_valid;
  assign mem_read_address = r_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;
  assign fetch_error      = r_err;

endmodule
